scope_capture: RTL and testbench

Trigger-and-capture front end of the scope datapath, placed directly upstream of the VGA display block. It takes the raw ADC sample stream and applies decimation. It waits for a level crossing on the selected slope, or for an auto-trigger timeout. It then emits exactly one screen's worth of scaled 9-bit samples (`sample`/`valid`) for the display to buffer. The display's `full` flag throttles re-arming so that one frame is never overwritten mid-scan.

---
 rtl/scope_pkg.sv | 20 ++
 rtl/scope_capture_trig_detect.sv | 45 ++++
 rtl/scope_capture.sv | 187 ++++++++++++++++++
 tb/tb_scope_capture.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and screen geometry for the scope capture path
`timescale 1ns/1ps

package scope_pkg;

    // ADC and display geometry
    localparam int ADC_W       = 12;
    localparam int SAMPLE_W    = 9;
    localparam int SCREEN_ROWS = 480;
    localparam int SCREEN_COLS = 640;

    // Capture sequencing: wait for display, hunt for trigger, stream one frame, hand off
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

endpackage

// File: rtl/scope_capture_trig_detect.sv
// rtl/scope_capture_trig_detect.sv - slope/level crossing detector on kept samples
`timescale 1ns/1ps

// Remembers the previous kept sample and flags a level crossing on the selected slope.
// hit_o is combinational so the crossing sample itself can be emitted as index 0.
module trig_detect
    import scope_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             update_i,
    input  logic [ADC_W-1:0] cur_i,
    input  logic [ADC_W-1:0] trig_i,
    input  logic             rising_i,
    output logic             hit_o
);

    logic [ADC_W-1:0] prev_q;
    logic             prev_valid_q;

    // Previous-sample history; cleared whenever the capture path is idle
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (update_i) begin
            prev_q       <= cur_i;
            prev_valid_q <= 1'b1;
        end
    end

    // Crossing test: the very first sample after clearing has no history and never hits
    always_comb begin
        hit_o = 1'b0;
        if (prev_valid_q) begin
            if (rising_i) begin
                hit_o = (prev_q < trig_i) && (cur_i >= trig_i);
            end else begin
                hit_o = (prev_q > trig_i) && (cur_i <= trig_i);
            end
        end
    end

endmodule

// File: rtl/scope_capture.sv
// rtl/scope_capture.sv - trigger-and-capture front end feeding the VGA display buffer
`timescale 1ns/1ps

// Decimates the ADC stream, waits for a trigger (level crossing or auto timeout),
// then emits exactly DEPTH scaled screen-row samples. The display's full flag
// gates re-arming so a frame being scanned out is never overwritten.
module scope_capture
    import scope_pkg::*;
#(
    parameter int DEPTH        = SCREEN_COLS,
    parameter int ROWS         = SCREEN_ROWS,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADC_W-1:0]    adc_data,
    input  logic                adc_valid,
    input  logic [3:0]          decim,
    input  logic [ADC_W-1:0]    trig,
    input  logic                rising,
    input  logic                auto_mode,
    input  logic                full,
    output logic [SAMPLE_W-1:0] sample,
    output logic                valid,
    output logic                triggered,
    output logic                capture_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [SAMPLE_W-1:0] ROW_MAX  = SAMPLE_W'(ROWS - 1);

    capture_state_t state_q, state_d;

    logic [3:0]          dec_cnt_q, dec_cnt_d;
    logic [3:0]          dec_lim_q, dec_lim_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                trig_q, trig_d;
    logic                done_q, done_d;

    logic                kept;
    logic                hit;
    logic                tmo_fire;
    logic                emit;
    logic [SAMPLE_W-1:0] row_raw;
    logic [SAMPLE_W-1:0] row_clamped;
    logic [SAMPLE_W-1:0] row_scaled;

    // A sample is kept on the first valid beat of every decimation period
    assign kept = adc_valid && (dec_cnt_q == 4'd0) && (state_q != IDLE);

    // Auto-trigger fires on the kept sample that finds the saturated count
    assign tmo_fire = auto_mode && (tmo_q == TMO_LAST);

    trig_detect u_trig_detect (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == IDLE),
        .update_i ((state_q == ARMED) && kept),
        .cur_i    (adc_data),
        .trig_i   (trig),
        .rising_i (rising),
        .hit_o    (hit)
    );

    // Screen mapping: top 9 ADC bits clamped to the visible rows, inverted so high volts draw high
    always_comb begin
        row_raw     = adc_data[ADC_W-1:ADC_W-SAMPLE_W];
        row_clamped = (row_raw > ROW_MAX) ? ROW_MAX : row_raw;
        row_scaled  = ROW_MAX - row_clamped;
    end

    // Decimation counter; a new decim value is only picked up when the count wraps
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        dec_lim_d = dec_lim_q;
        if (state_q == IDLE) begin
            dec_cnt_d = 4'd0;
            dec_lim_d = decim;
        end else if (adc_valid) begin
            if (dec_cnt_q >= dec_lim_q) begin
                dec_cnt_d = 4'd0;
                dec_lim_d = decim;
            end else begin
                dec_cnt_d = dec_cnt_q + 4'd1;
            end
        end
    end

    // Capture sequencing, timeout counting and output staging
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        trig_d   = 1'b0;
        done_d   = 1'b0;
        emit     = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                tmo_d = '0;
                if (!full) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (kept) begin
                    if (auto_mode && (tmo_q != TMO_LAST)) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    if (hit || tmo_fire) begin
                        emit    = 1'b1;
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                trig_d = 1'b1;
                if (kept) begin
                    emit = 1'b1;
                end
            end
            DONE: begin
                if (full) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared emission path for the trigger sample and every captured sample
        if (emit) begin
            valid_d  = 1'b1;
            sample_d = row_scaled;
            trig_d   = 1'b1;
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dec_cnt_q <= '0;
            dec_lim_q <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_cnt_q <= dec_cnt_d;
            dec_lim_q <= dec_lim_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
        end
    end

    assign sample       = sample_q;
    assign valid        = valid_q;
    assign triggered    = trig_q;
    assign capture_done = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// tb/tb_scope_capture.sv - randomized self-checking bench for scope_capture
`timescale 1ns/1ps

module tb_scope_capture;

    localparam int DEPTH  = 640;
    localparam int ROWS   = 480;
    localparam int AUTO_T = 16;
    localparam int MAXN   = 10000;
    localparam int NEVER  = 1000000;

    localparam int M_UP    = 0;
    localparam int M_DN    = 1;
    localparam int M_CONST = 2;
    localparam int M_RAND  = 3;
    localparam int M_WALK  = 4;
    localparam int M_SAW   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [3:0]  decim;
    logic [11:0] trig;
    logic        rising;
    logic        auto_mode;
    logic        full;
    logic [8:0]  sample;
    logic        valid;
    logic        triggered;
    logic        capture_done;

    always #10 clk = ~clk;

    scope_capture #(
        .DEPTH        (DEPTH),
        .ROWS         (ROWS),
        .AUTO_TIMEOUT (AUTO_T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .decim        (decim),
        .trig         (trig),
        .rising       (rising),
        .auto_mode    (auto_mode),
        .full         (full),
        .sample       (sample),
        .valid        (valid),
        .triggered    (triggered),
        .capture_done (capture_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] st_data [MAXN];
    bit          st_vld  [MAXN];
    int          exp_cyc [$];
    int          exp_smp [$];

    int r_got;
    int r_first;
    int r_first_c;
    int r_gap_bad;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_row(input int v);
        int r;
        r = v / 8;
        if (r > ROWS - 1) r = ROWS - 1;
        return (ROWS - 1) - r;
    endfunction

    task automatic gen(input int mode, input int n, input int vpct, input int cval);
        int k;
        int w;
        int v;
        k = 0;
        w = cval;
        for (int c = 0; c < n; c++) begin
            st_vld[c] = ($urandom_range(99) < vpct);
            case (mode)
                M_UP:    begin v = 2000 + 10 * k; if (v > 2100) v = 2100; end
                M_DN:    begin v = 2100 - 10 * k; if (v < 2000) v = 2000; end
                M_CONST: v = cval;
                M_RAND:  v = int'($urandom_range(4095));
                M_WALK:  begin
                    w = w + int'($urandom_range(64)) - 32;
                    if (w < 0) w = 0;
                    if (w > 4095) w = 4095;
                    v = w;
                end
                default: v = ((k % 8) < 4) ? 1000 : 3000;
            endcase
            st_data[c] = 12'(v);
            if (st_vld[c]) k++;
        end
    endtask

    // Reference: walk the valid samples, keep every (dec+1)-th, hunt for the trigger,
    // then list the DEPTH kept samples that should appear on the output.
    task automatic model(input int n, input int dec, input int trg, input bit rise, input bit autom);
        int  vcount;
        int  kept_n;
        int  prev;
        int  cur;
        bit  armed;
        bit  fire;
        vcount = 0;
        kept_n = 0;
        prev   = -1;
        armed  = 1'b1;
        exp_cyc.delete();
        exp_smp.delete();
        for (int c = 0; c < n; c++) begin
            if (st_vld[c]) begin
                if ((vcount % (dec + 1)) == 0) begin
                    cur = int'(st_data[c]);
                    if (armed) begin
                        fire = (prev >= 0) && (rise ? (prev < trg && cur >= trg)
                                                    : (prev > trg && cur <= trg));
                        if (autom && kept_n == AUTO_T - 1) fire = 1'b1;
                        if (fire) armed = 1'b0;
                        prev = cur;
                        kept_n++;
                    end
                    if (!armed && exp_cyc.size() < DEPTH) begin
                        exp_cyc.push_back(c);
                        exp_smp.push_back(ref_row(cur));
                    end
                end
                vcount++;
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        full      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int n, input int dec, input int trg,
                       input bit rise, input bit autom, input int abort_at, input bit rst);
        int got, bad_pos, bad_smp, bad_trig, bad_done, dones, first_c, last_c, prev_c;
        bit exp_t;
        got = 0; bad_pos = 0; bad_smp = 0; bad_trig = 0; bad_done = 0; dones = 0; prev_c = -1;
        decim     = 4'(dec);
        trig      = 12'(trg);
        rising    = rise;
        auto_mode = autom;
        if (rst) do_reset();
        model(n, dec, trg, rise, autom);
        first_c   = (exp_cyc.size() > 0) ? exp_cyc[0] : NEVER;
        last_c    = (exp_cyc.size() == DEPTH) ? exp_cyc[DEPTH-1] : NEVER;
        r_first   = -1;
        r_first_c = -1;
        r_gap_bad = 0;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (c > 0) begin
                if (valid) begin
                    if (got < exp_cyc.size()) begin
                        if (exp_cyc[got] != c - 1) bad_pos++;
                        if (int'(sample) != exp_smp[got]) bad_smp++;
                    end
                    if (got == 0) begin
                        r_first   = int'(sample);
                        r_first_c = c - 1;
                    end
                    if (prev_c >= 0 && (c - prev_c) != dec + 1) r_gap_bad++;
                    prev_c = c;
                    got++;
                end
                if (capture_done) begin
                    dones++;
                    if (!valid || got != DEPTH) bad_done++;
                end
                exp_t = ((c - 1) >= first_c) && ((c - 1) <= last_c);
                if (triggered != exp_t) bad_trig++;
            end
            if (abort_at > 0 && got == abort_at) begin
                reset     = 1'b1;
                adc_valid = 1'b1;
                @(posedge clk);
                #1;
                check({tag, ".valid_after_reset"}, int'(valid), 0);
                check({tag, ".triggered_after_reset"}, int'(triggered), 0);
                check({tag, ".done_after_reset"}, int'(capture_done), 0);
                check({tag, ".sample_after_reset"}, int'(sample), 0);
                check({tag, ".no_done_partial"}, dones, 0);
                check({tag, ".partial_samples"}, bad_smp, 0);
                reset     = 1'b0;
                adc_valid = 1'b0;
                r_got     = got;
                return;
            end
            if (c < n) begin
                adc_data  = st_data[c];
                adc_valid = st_vld[c];
            end else begin
                adc_valid = 1'b0;
            end
        end
        check({tag, ".strobes"}, got, exp_cyc.size());
        check({tag, ".timing"}, bad_pos, 0);
        check({tag, ".samples"}, bad_smp, 0);
        check({tag, ".triggered"}, bad_trig, 0);
        check({tag, ".done_count"}, dones, (exp_cyc.size() == DEPTH) ? 1 : 0);
        check({tag, ".done_place"}, bad_done, 0);
        r_got = got;
    endtask

    task automatic hs_step(input int k, inout int vcnt);
        adc_data  = ((k % 8) < 4) ? 12'd1000 : 12'd3000;
        adc_valid = 1'b1;
        @(posedge clk);
        #1;
        if (valid) vcnt++;
    endtask

    initial begin
        int hs_cnt;
        int hs_k;
        int dec, trg, mode, vpct;
        bit rise, autom;

        reset = 1'b1; adc_data = '0; adc_valid = 1'b0; decim = '0; trig = '0;
        rising = 1'b1; auto_mode = 1'b0; full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.sample", int'(sample), 0);
        check("reset.valid", int'(valid), 0);
        check("reset.triggered", int'(triggered), 0);
        check("reset.capture_done", int'(capture_done), 0);

        gen(M_UP, 1000, 100, 0);
        run("rise", 1000, 0, 2048, 1'b1, 1'b0, 0, 1'b1);
        check("rise.first_sample", r_first, 223);
        check("rise.total", r_got, DEPTH);

        hs_cnt = 0;
        hs_k   = 0;
        for (int i = 0; i < 300; i++) begin hs_step(hs_k, hs_cnt); hs_k++; end
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin hs_step(hs_k, hs_cnt); hs_k++; end
        check("handshake.no_rearm", hs_cnt, 0);
        full = 1'b0;
        for (int i = 0; i < 300 && hs_cnt == 0; i++) begin hs_step(hs_k, hs_cnt); hs_k++; end
        check("handshake.rearm", (hs_cnt > 0) ? 1 : 0, 1);

        gen(M_UP, 1000, 100, 0);
        run("fall_up", 1000, 0, 2048, 1'b0, 1'b0, 0, 1'b1);
        check("fall_up.none", r_got, 0);
        gen(M_DN, 1000, 100, 0);
        run("fall_dn", 1000, 0, 2048, 1'b0, 1'b0, 0, 1'b1);
        check("fall_dn.first_sample", r_first, 224);

        gen(M_CONST, 1000, 100, 1000);
        run("auto", 1000, 0, 2048, 1'b1, 1'b1, 0, 1'b1);
        check("auto.first_sample", r_first, 354);
        check("auto.first_cycle", r_first_c, AUTO_T - 1);
        gen(M_CONST, MAXN, 100, 1000);
        run("auto_off", MAXN, 0, 2048, 1'b1, 1'b0, 0, 1'b1);
        check("auto_off.none", r_got, 0);

        gen(M_UP, 4000, 100, 0);
        run("decim", 4000, 3, 2048, 1'b1, 1'b0, 0, 1'b1);
        check("decim.gap", r_gap_bad, 0);
        check("decim.total", r_got, DEPTH);

        gen(M_CONST, 1000, 100, 4095);
        run("clamp", 1000, 0, 2048, 1'b1, 1'b1, 0, 1'b1);
        check("clamp.first_sample", r_first, 0);

        gen(M_UP, 1000, 100, 0);
        run("abort", 1000, 0, 2048, 1'b1, 1'b0, 300, 1'b1);
        check("abort.reached", r_got, 300);
        gen(M_UP, 1000, 100, 0);
        run("post_abort", 1000, 0, 2048, 1'b1, 1'b0, 0, 1'b0);
        check("post_abort.total", r_got, DEPTH);

        for (int i = 0; i < 5; i++) begin
            dec   = int'($urandom_range(3));
            trg   = int'($urandom_range(3500, 500));
            rise  = 1'($urandom_range(1));
            autom = 1'($urandom_range(1));
            mode  = ($urandom_range(1) == 0) ? M_RAND : M_WALK;
            vpct  = int'($urandom_range(100, 60));
            gen(mode, 5000, vpct, trg);
            run($sformatf("rand%0d", i), 5000, dec, trg, rise, autom, 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
